// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter and sequencer for a single-port synchronous data memory.
// Optional DMEM_ARB_ZERO_GUARD_EN: address-0 accesses are blocked here, reads return 0, writes pulse err_zw.
module dmem_arbiter #(
    parameter int A         = 7,
    parameter int D         = 8,
    parameter int BURST_MAX = 4,
    parameter int CW        = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0,
    input  logic         req1,
    input  logic         we0,
    input  logic         we1,
    input  logic [A-1:0] addr0,
    input  logic [A-1:0] addr1,
    input  logic [D-1:0] wdata0,
    input  logic [D-1:0] wdata1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         rvalid0,
    output logic         rvalid1,
    output logic [D-1:0] rdata,
    output logic         mem_ce,
    output logic         mem_we,
    output logic [A-1:0] mem_addr,
    output logic [D-1:0] mem_data,
    input  logic [D-1:0] mem_q
`ifdef DMEM_ARB_ZERO_GUARD_EN
    ,
    output logic         err_zw
`endif
);

    localparam logic [CW-1:0] CNT_MAX = CW'(BURST_MAX);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic          owner_reg;
    logic [CW-1:0] cnt_reg;
    logic          rd_pend_reg;
    logic          rd_tag_reg;

    logic [1:0]    req_v;
    logic [1:0]    gnt_v;
    logic          tie_winner;
    logic          accept;
    logic          acc_id;
    logic          sel_we;
    logic [A-1:0]  sel_addr;
    logic [D-1:0]  sel_wdata;
    logic          acc_zero;

    assign req_v = {req1, req0};

    // On a tie the owner keeps the port only while its burst is below the cap;
    // an idle cycle saturates cnt so the next tie goes to the other side.
    assign tie_winner = (cnt_reg < CNT_MAX) ? owner_reg : ~owner_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_grant
            localparam logic ID = (gi == 1) ? 1'b1 : 1'b0;
            assign gnt_v[gi] = req_v[gi] & (~req_v[1-gi] | (tie_winner == ID));
        end
    endgenerate

    assign gnt0      = gnt_v[0];
    assign gnt1      = gnt_v[1];
    assign accept    = |gnt_v;
    assign acc_id    = gnt_v[1];
    assign sel_we    = acc_id ? we1 : we0;
    assign sel_addr  = acc_id ? addr1 : addr0;
    assign sel_wdata = acc_id ? wdata1 : wdata0;

`ifdef DMEM_ARB_ZERO_GUARD_EN
    assign acc_zero = (sel_addr == '0);
`else
    assign acc_zero = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_reg   <= 1'b1;
            cnt_reg     <= CNT_MAX;
            rd_pend_reg <= 1'b0;
            rd_tag_reg  <= 1'b0;
            mem_ce      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_data    <= '0;
            rvalid0     <= 1'b0;
            rvalid1     <= 1'b0;
        end else begin
            rvalid0 <= rd_pend_reg & ~rd_tag_reg;
            rvalid1 <= rd_pend_reg & rd_tag_reg;
            if (accept) begin
                mem_ce      <= ~acc_zero;
                mem_we      <= sel_we & ~acc_zero;
                mem_addr    <= sel_addr;
                mem_data    <= sel_wdata;
                rd_pend_reg <= ~sel_we;
                if (!sel_we) begin
                    rd_tag_reg <= acc_id;
                end
                if (acc_id == owner_reg) begin
                    cnt_reg <= (cnt_reg >= CNT_MAX) ? CNT_MAX : cnt_reg + CNT_ONE;
                end else begin
                    owner_reg <= acc_id;
                    cnt_reg   <= CNT_ONE;
                end
            end else begin
                mem_ce      <= 1'b0;
                mem_we      <= 1'b0;
                rd_pend_reg <= 1'b0;
                cnt_reg     <= CNT_MAX;
            end
        end
    end

`ifdef DMEM_ARB_ZERO_GUARD_EN
    logic rd_zero_reg;
    logic rd_zero_out_reg;

    // Blocked address-0 reads follow the normal read pipeline; the flag substitutes 0 for mem_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_zero_reg     <= 1'b0;
            rd_zero_out_reg <= 1'b0;
            err_zw          <= 1'b0;
        end else begin
            rd_zero_reg     <= accept & acc_zero & ~sel_we;
            rd_zero_out_reg <= rd_zero_reg;
            err_zw          <= accept & acc_zero & sel_we;
        end
    end

    assign rdata = rd_zero_out_reg ? '0 : mem_q;
`else
    assign rdata = mem_q;
`endif

endmodule
